// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with a valid strobe and error flags.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PAR_ODD    = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RXD,
    input  logic                  RX_tick,
    input  logic                  par_EN,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // With voting the decision waits for the tick after the centre, so every
    // bit decision lands one tick later while bit-to-bit spacing is unchanged.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] START_CNT = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] START_CNT = CW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [CW-1:0] BIT_CNT  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic          ODD      = (PAR_ODD != 0);

    logic                  sync1, sync2;
    logic                  prev_sample;
    logic                  bit_sample;
    logic [2:0]            state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q;
    logic                  par_bad;

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= RXD;
            sync2 <= sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic older_sample;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_sample  <= 1'b1;
            older_sample <= 1'b1;
        end else if (RX_tick) begin
            prev_sample  <= sync2;
            older_sample <= prev_sample;
        end
    end

    assign bit_sample = (older_sample & prev_sample) | (older_sample & sync2) | (prev_sample & sync2);
`else
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) prev_sample <= 1'b1;
        else if (RX_tick) prev_sample <= sync2;
    end

    assign bit_sample = sync2;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_bad    <= 1'b0;
            RX_DATA    <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (RX_tick) begin
                case (state)
                    S_IDLE: begin
                        // Falling edge only: a line stuck low cannot retrigger.
                        if (!sync2 && prev_sample) begin
                            state    <= S_START;
                            cnt      <= '0;
                            par_en_q <= par_EN;
                            busy     <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (cnt == START_CNT) begin
                            cnt <= '0;
                            if (!bit_sample) begin
                                state   <= S_DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt == BIT_CNT) begin
                            cnt     <= '0;
                            shreg   <= DATA_WIDTH'({bit_sample, shreg} >> 1);
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == LAST_BIT) state <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (cnt == BIT_CNT) begin
                            cnt     <= '0;
                            par_bad <= bit_sample ^ (^shreg) ^ ODD;
                            state   <= S_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (cnt == BIT_CNT) begin
                            cnt        <= '0;
                            data_valid <= 1'b1;
                            RX_DATA    <= shreg;
                            par_err    <= par_en_q & par_bad;
                            stop_err   <= ~bit_sample;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are built as per-tick line levels and
// decoded by a bit-centre reference model; covers parity, false start, stop errors, reset, glitch.
module tb_uart_rx;

    localparam int       OS      = 16;
    localparam int       DW      = 8;
    localparam bit       PAR_ODD = 1'b0;
    localparam int       CENTRE  = OS / 2;

    typedef bit slot_q_t[$];
    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          serr;
    } rec_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RXD = 1'b1;
    logic          RX_tick = 1'b0;
    logic          par_EN = 1'b0;
    logic [DW-1:0] RX_DATA;
    logic          data_valid, par_err, stop_err, busy;

    int   errors = 0;
    int   checks = 0;
    rec_t got_q[$];

    uart_rx #(.OVERSAMPLE(OS), .DATA_WIDTH(DW), .PAR_ODD(0)) dut (
        .CLK(CLK), .RST(RST), .RXD(RXD), .RX_tick(RX_tick), .par_EN(par_EN),
        .RX_DATA(RX_DATA), .data_valid(data_valid), .par_err(par_err),
        .stop_err(stop_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (data_valid) got_q.push_back({RX_DATA, par_err, stop_err});

    // One slot = one oversample tick period; the line settles well before the tick.
    task automatic drive_slot(input bit v);
        @(negedge CLK) RXD = v;
        repeat (2) @(negedge CLK);
        @(negedge CLK) RX_tick = 1'b1;
        @(negedge CLK) RX_tick = 1'b0;
    endtask

    task automatic drive_slots(input slot_q_t s, input int flip_at);
        for (int i = 0; i < s.size(); i++) begin
            if (i == flip_at) par_EN = ~par_EN;
            drive_slot(s[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_slot(1'b1);
    endtask

    function automatic slot_q_t build_frame(input logic [DW-1:0] d, input bit pen, input bit pbit, input bit sbit);
        slot_q_t q;
        q = {};
        for (int i = 0; i < OS; i++) q.push_back(1'b0);
        for (int b = 0; b < DW; b++)
            for (int i = 0; i < OS; i++) q.push_back(d[b]);
        if (pen)
            for (int i = 0; i < OS; i++) q.push_back(pbit);
        for (int i = 0; i < OS; i++) q.push_back(sbit);
        return q;
    endfunction

    // Line level seen for the bit whose centre is slot c.
    function automatic bit sample_at(input slot_q_t s, input int c);
`ifdef UART_RX_MAJORITY_EN
        return (int'(s[c-1]) + int'(s[c]) + int'(s[c+1])) >= 2;
`else
        return s[c];
`endif
    endfunction

    function automatic rec_t model(input slot_q_t s, input bit pen);
        rec_t r;
        bit   pb;
        for (int k = 0; k < DW; k++) r.data[k] = sample_at(s, CENTRE + OS * (k + 1));
        pb     = sample_at(s, CENTRE + OS * (DW + 1));
        r.perr = pen ? (pb ^ (^r.data) ^ PAR_ODD) : 1'b0;
        r.serr = ~sample_at(s, CENTRE + OS * (DW + 1 + int'(pen)));
        return r;
    endfunction

    task automatic run_frame(input slot_q_t s, input bit pen, input int flip_at, output int n, output rec_t r);
        int n0;
        n0     = got_q.size();
        par_EN = pen;
        drive_slots(s, flip_at);
        idle(2);
        n = got_q.size() - n0;
        r = (n > 0) ? got_q[$] : '0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks += 5;
        if (RX_DATA !== '0)    begin errors++; $display("FAIL reset_data got=%h want=00", RX_DATA); end
        if (data_valid !== 0)  begin errors++; $display("FAIL reset_valid got=%b want=0", data_valid); end
        if (par_err !== 0)     begin errors++; $display("FAIL reset_perr got=%b want=0", par_err); end
        if (stop_err !== 0)    begin errors++; $display("FAIL reset_serr got=%b want=0", stop_err); end
        if (busy !== 0)        begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        RST = 1'b1;
        idle(3);
    endtask

    task automatic test_basic();
        slot_q_t s; rec_t r, exp; int n;
        s   = build_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        exp = model(s, 1'b0);
        run_frame(s, 1'b0, -1, n, r);
        checks += 4;
        if (n !== 1)          begin errors++; $display("FAIL basic_count got=%0d want=1", n); end
        if (r !== exp)        begin errors++; $display("FAIL basic_rec got=%h/%b/%b want=%h/%b/%b", r.data, r.perr, r.serr, exp.data, exp.perr, exp.serr); end
        if (r.data !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h want=a5", r.data); end
        if (busy !== 0)       begin errors++; $display("FAIL basic_busy got=%b want=0", busy); end
    endtask

    task automatic test_parity();
        slot_q_t s; rec_t r, exp; int n;
        for (int p = 0; p < 2; p++) begin
            s   = build_frame(8'h3C, 1'b1, p[0], 1'b1);
            exp = model(s, 1'b1);
            run_frame(s, 1'b1, -1, n, r);
            checks += 3;
            if (n !== 1)            begin errors++; $display("FAIL parity%0d_count got=%0d want=1", p, n); end
            if (r !== exp)          begin errors++; $display("FAIL parity%0d_rec got=%h/%b/%b want=%h/%b/%b", p, r.data, r.perr, r.serr, exp.data, exp.perr, exp.serr); end
            if (r.perr !== p[0])    begin errors++; $display("FAIL parity%0d_perr got=%b want=%b", p, r.perr, p[0]); end
        end
    endtask

    task automatic test_false_start();
        slot_q_t s; rec_t r, exp; int n, n0;
        n0 = got_q.size();
        for (int i = 0; i < 4; i++) drive_slot(1'b0);
        checks += 1;
        if (busy !== 1) begin errors++; $display("FAIL false_busy_hi got=%b want=1", busy); end
        idle(OS);
        checks += 2;
        if (busy !== 0)              begin errors++; $display("FAIL false_busy_lo got=%b want=0", busy); end
        if (got_q.size() !== n0)     begin errors++; $display("FAIL false_strobe got=%0d want=%0d", got_q.size(), n0); end
        s   = build_frame(8'h11, 1'b0, 1'b0, 1'b1);
        exp = model(s, 1'b0);
        run_frame(s, 1'b0, -1, n, r);
        checks += 2;
        if (n !== 1)   begin errors++; $display("FAIL false_next_count got=%0d want=1", n); end
        if (r !== exp) begin errors++; $display("FAIL false_next_rec got=%h want=%h", r, exp); end
    endtask

    task automatic test_stop_err();
        slot_q_t s, t; rec_t r, exp; int n;
        s   = build_frame(8'h55, 1'b0, 1'b0, 1'b0);
        exp = model(s, 1'b0);
        t   = s;
        for (int i = 0; i < 3 * OS; i++) t.push_back(1'b0);
        run_frame(t, 1'b0, -1, n, r);
        checks += 3;
        if (n !== 1)     begin errors++; $display("FAIL stop_count got=%0d want=1", n); end
        if (r !== exp)   begin errors++; $display("FAIL stop_rec got=%h want=%h", r, exp); end
        if (r.serr !== 1) begin errors++; $display("FAIL stop_serr got=%b want=1", r.serr); end
        idle(OS);
        s   = build_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        exp = model(s, 1'b0);
        run_frame(s, 1'b0, -1, n, r);
        checks += 3;
        if (n !== 1)          begin errors++; $display("FAIL stop_next_count got=%0d want=1", n); end
        if (r.data !== 8'h0F) begin errors++; $display("FAIL stop_next_data got=%h want=0f", r.data); end
        if (r.serr !== 0)     begin errors++; $display("FAIL stop_next_serr got=%b want=0", r.serr); end
    endtask

    task automatic test_reset_mid();
        slot_q_t s; rec_t r, exp; int n, n0;
        s  = build_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        n0 = got_q.size();
        for (int i = 0; i < OS * 5 + 5; i++) drive_slot(s[i]);
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK) #1;
        checks += 5;
        if (RX_DATA !== '0)   begin errors++; $display("FAIL rstmid_data got=%h want=00", RX_DATA); end
        if (data_valid !== 0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", data_valid); end
        if (par_err !== 0)    begin errors++; $display("FAIL rstmid_perr got=%b want=0", par_err); end
        if (stop_err !== 0)   begin errors++; $display("FAIL rstmid_serr got=%b want=0", stop_err); end
        if (busy !== 0)       begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        RXD = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        idle(3);
        checks += 1;
        if (got_q.size() !== n0) begin errors++; $display("FAIL rstmid_strobe got=%0d want=%0d", got_q.size(), n0); end
        s   = build_frame(8'h81, 1'b0, 1'b0, 1'b1);
        exp = model(s, 1'b0);
        run_frame(s, 1'b0, -1, n, r);
        checks += 2;
        if (n !== 1)          begin errors++; $display("FAIL rstmid_next_count got=%0d want=1", n); end
        if (r.data !== 8'h81) begin errors++; $display("FAIL rstmid_next_data got=%h want=81 (model %h)", r.data, exp.data); end
    endtask

    task automatic test_glitch();
        slot_q_t s; rec_t r; int n; logic [DW-1:0] want;
`ifdef UART_RX_MAJORITY_EN
        want = 8'h00;
`else
        want = 8'h04;
`endif
        s = build_frame(8'h00, 1'b0, 1'b0, 1'b1);
        s[CENTRE + OS * 3] = 1'b1;
        run_frame(s, 1'b0, -1, n, r);
        checks += 2;
        if (n !== 1)       begin errors++; $display("FAIL glitch_count got=%0d want=1", n); end
        if (r.data !== want) begin errors++; $display("FAIL glitch_data got=%h want=%h", r.data, want); end
    endtask

    task automatic test_random();
        slot_q_t s; rec_t r, exp; int n; bit pen;
        for (int k = 0; k < 16; k++) begin
            pen = 1'($urandom_range(0, 1));
            s   = build_frame(8'($urandom), pen, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            exp = model(s, pen);
            run_frame(s, pen, $urandom_range(20, 120), n, r);
            checks += 2;
            if (n !== 1)   begin errors++; $display("FAIL random%0d_count got=%0d want=1", k, n); end
            if (r !== exp) begin errors++; $display("FAIL random%0d_rec got=%h/%b/%b want=%h/%b/%b", k, r.data, r.perr, r.serr, exp.data, exp.perr, exp.serr); end
        end
    endtask

    task automatic test_back_to_back();
        slot_q_t s, all; rec_t exp_q[$]; bit pen; int n0;
        all = {};
        pen = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s = build_frame(8'($urandom), pen, 1'($urandom_range(0, 1)), 1'b1);
            exp_q.push_back(model(s, pen));
            all = {all, s};
        end
        n0     = got_q.size();
        par_EN = pen;
        drive_slots(all, -1);
        idle(2);
        checks += 1;
        if (got_q.size() !== n0 + 4) begin
            errors++; $display("FAIL b2b_count got=%0d want=4", got_q.size() - n0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks += 1;
                if (got_q[n0 + k] !== exp_q[k]) begin
                    errors++; $display("FAIL b2b%0d_rec got=%h want=%h", k, got_q[n0 + k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_stop_err();
        test_reset_mid();
        test_glitch();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
